// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and constants for sequence_generator.
//   state_t         - FSM state encoding
//   MAX_LEN_DEFAULT - default maximum pattern length
//   LEN_W / REP_W   - widths of the length and repetition fields
//   even_parity()   - XOR of the low n bits of a pattern
// The PARITY state exists only when SEQ_GEN_PARITY_EN is defined.
package seq_gen_pkg;

  localparam int unsigned MAX_LEN_DEFAULT = 8;
  localparam int unsigned LEN_W           = 4;
  localparam int unsigned REP_W           = 4;
  localparam int unsigned PAT_MAX         = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
`ifdef SEQ_GEN_PARITY_EN
    , PARITY = 3'd5
`endif
  } state_t;

  function automatic logic even_parity(input logic [PAT_MAX-1:0] bits,
                                       input logic [LEN_W-1:0]   n);
    logic                p;
    logic [PAT_MAX-1:0]  b;
    p = 1'b0;
    b = bits;
    for (int unsigned i = 0; i < PAT_MAX; i++) begin
      if (i < 32'(n)) p = p ^ b[0];
      b = b >> 1;
    end
    return p;
  endfunction

endpackage

// File: rtl/sequence_generator_shifter.sv
// seq_gen_shifter: captured pattern/length and the current bit index.
//   clock, reset   - clock, synchronous active-high reset
//   load           - capture pattern_in/len_in, index <= len_in-1
//   shift          - advance index; wraps to len-1 after index 0
//   pattern_in     - pattern to capture
//   len_in         - active length to capture
//   bit_out        - pattern bit at the current index
//   is_last        - current index is 0
//   parity_out     - even parity of the active bits (SEQ_GEN_PARITY_EN only)
module seq_gen_shifter
  import seq_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern_in,
  input  logic [LEN_W-1:0]   len_in,
  output logic               bit_out,
  output logic               is_last
`ifdef SEQ_GEN_PARITY_EN
  ,
  output logic               parity_out
`endif
);

  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;

  always_comb begin
    pattern_d = pattern_q;
    len_d     = len_q;
    idx_d     = idx_q;
    if (load) begin
      pattern_d = pattern_in;
      len_d     = len_in;
      idx_d     = len_in - LEN_W'(1);
    end else if (shift) begin
      // Wrapping here means the next repetition starts at len-1 without
      // a separate reload from the FSM.
      idx_d = (idx_q == '0) ? (len_q - LEN_W'(1)) : (idx_q - LEN_W'(1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pattern_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
    end else begin
      pattern_q <= pattern_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
    end
  end

  assign bit_out = |(pattern_q & (MAX_LEN'(1) << idx_q));
  assign is_last = (idx_q == '0);

`ifdef SEQ_GEN_PARITY_EN
  assign parity_out = even_parity(PAT_MAX'(pattern_q), len_q);
`endif

endmodule

// File: rtl/sequence_generator.sv
// sequence_generator: serialises a captured pattern MSB first, repeated
// repeat_cnt+1 times with a one-cycle gap between repetitions.
//   clock, reset - clock, synchronous active-high reset
//   start        - transmit request (sampled in IDLE only)
//   pattern      - bits to send, active bits pattern[len-1:0]
//   len          - active length, legal 1..MAX_LEN
//   repeat_cnt   - additional repetitions
//   o, o_valid   - serial bit and its qualifier
//   last         - final bit of a repetition
//   busy         - LOAD/SHIFT/PARITY/GAP
//   done         - pulse after the final repetition
//   err          - pulse on a rejected start
// Optional: SEQ_GEN_PARITY_EN appends an even-parity bit per repetition.
// All outputs are registered from the current state, so they trail the
// state register by one cycle.
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic [REP_W-1:0]   repeat_cnt,
  output logic               o,
  output logic               o_valid,
  output logic               last,
  output logic               busy,
  output logic               done,
  output logic               err
);

  state_t             state_q, state_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic               o_q, o_d, o_valid_q, o_valid_d, last_q, last_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               load, shift, len_ok;
  logic               sh_bit, sh_last;
`ifdef SEQ_GEN_PARITY_EN
  logic               sh_parity;
`endif

  seq_gen_shifter #(.MAX_LEN(MAX_LEN)) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .pattern_in (pattern),
    .len_in     (len),
    .bit_out    (sh_bit),
    .is_last    (sh_last)
`ifdef SEQ_GEN_PARITY_EN
    ,
    .parity_out (sh_parity)
`endif
  );

  assign len_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    load    = 1'b0;
    shift   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            load    = 1'b1;
            rep_d   = repeat_cnt;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: state_d = SHIFT;
      SHIFT: begin
        shift = 1'b1;
        if (sh_last) begin
`ifdef SEQ_GEN_PARITY_EN
          state_d = PARITY;
`else
          state_d = (rep_q != '0) ? GAP : DONE;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: state_d = (rep_q != '0) ? GAP : DONE;
`endif
      GAP: begin
        rep_d   = rep_q - REP_W'(1);
        state_d = SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_d       = (state_q == SHIFT) && sh_bit;
    o_valid_d = (state_q == SHIFT);
`ifdef SEQ_GEN_PARITY_EN
    o_d       = o_d || ((state_q == PARITY) && sh_parity);
    o_valid_d = o_valid_d || (state_q == PARITY);
    last_d    = (state_q == PARITY);
    busy_d    = (state_q == LOAD) || (state_q == SHIFT) ||
                (state_q == PARITY) || (state_q == GAP);
`else
    last_d    = (state_q == SHIFT) && sh_last;
    busy_d    = (state_q == LOAD) || (state_q == SHIFT) || (state_q == GAP);
`endif
    done_d    = (state_q == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rep_q     <= '0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_q     <= rep_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o       = o_q;
  assign o_valid = o_valid_q;
  assign last    = last_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
